day_set_ctrl: RTL and testbench
===============================

Name: day_set_ctrl

Overview:
Sequential controller for the day-of-week display digits. It holds the current day code (0=Mon … 6=Sun) and advances it on a midnight tick. A user SET mode lets the day be edited with inc/dec buttons. While editing, the day digits blink, and SET mode exits on a mode press or an inactivity timeout. It also time-multiplexes the day code onto the per-letter seven-segment decoders by scanning one-hot active-low digit anodes.

Parameters:
NUM_DIGITS, 3, number of scanned letter digits (the decoders take the same day code).
TIMEOUT_TICKS, 16, blink_tick periods without a button press before SET auto-exits; legal range 2..255.
DAYS, 7, modulus of the day counter; legal codes are 0..DAYS-1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
day_tick  in  1  single-cycle pulse: advance day (midnight).
scan_tick  in  1  single-cycle pulse: advance digit scan.
blink_tick  in  1  single-cycle pulse: blink half-period / timeout time base.
btn_mode  in  1  single-cycle debounced pulse: enter/leave SET.
btn_inc  in  1  single-cycle debounced pulse: day +1 in SET.
btn_dec  in  1  single-cycle debounced pulse: day -1 in SET.
day  out  3  current day code, fed to the segment decoders.
set_mode  out  1  high while in SET.
digit_an  out  NUM_DIGITS  one-hot active-low anode enables.
digit_idx  out  2  index of the active digit (selects the letter decoder).
blank  out  1  high = suppress segments (blink off phase).

Behaviour:
- All outputs are registered. Each input pulse takes effect on the clock edge where it is sampled, so outputs change 1 cycle after the pulse.
- Reset (async assert, sync release of state) forces: day=0, state RUN, set_mode=0, digit_idx=0, digit_an=all ones except bit0=0, blank=0, blink phase=0, timeout count=0. Asserting reset mid-edit discards the edit.
- States:
  - RUN: day_tick advances day, wrapping 6->0. btn_inc/btn_dec are ignored. btn_mode goes to SET.
  - SET: btn_inc advances day +1 (6->0) and btn_dec advances day -1 (0->6). day_tick is ignored, i.e. the midnight advance is lost. btn_mode goes to RUN and keeps the edited day. The timeout also goes to RUN and keeps the edited day.
- Entering SET clears the blink phase and timeout count, so the digits are visible first.
- In SET, each blink_tick toggles the blink phase and increments the timeout count.
- In SET, any btn_inc or btn_dec (including both at once) clears the blink phase and timeout count.
- Timeout: on the blink_tick that brings the count to TIMEOUT_TICKS, the FSM moves to RUN and set_mode falls the next cycle.
- blank = set_mode AND blink phase. blank=0 in RUN at all times.
- Simultaneous events:
  - btn_mode has priority over inc/dec in both states; a coincident inc/dec is dropped.
  - btn_inc and btn_dec together: day unchanged.
  - In RUN, day_tick together with btn_mode: day advances AND the FSM enters SET.
  - A timeout blink_tick together with btn_inc/btn_dec: the button wins, the count clears and the FSM stays in SET.
  - A timeout blink_tick together with btn_mode: exits to RUN once.
- Scan: runs in every state. Each scan_tick advances digit_idx 0->1->…->NUM_DIGITS-1->0, and digit_an tracks it with exactly one bit low.
- day never holds a code >= DAYS.

Decomposition:
- Shared package day_pkg holds:
  - day codes MON=0, TUE=1, WED=2, THU=3, FRI=4, SAT=5, SUN=6;
  - DAYS=7;
  - state encoding RUN/SET.
- One natural sub-module, digit_scanner (scan_tick -> digit_idx, digit_an), instantiated once.
- Day counter, FSM, blink and timeout logic live in the top.

Test Plan:
- Reset mid-SET with day=4 and blank=1: pull rst_n low without a clock -> immediately day=0, set_mode=0, blank=0, digit_an=110, digit_idx=0.
- RUN wrap: 6 day_tick pulses from reset -> day=6; the 7th -> day=0. btn_inc pulses in RUN -> day unchanged.
- SET edit:
  - btn_mode -> set_mode=1 next cycle;
  - btn_dec -> day=6;
  - btn_inc twice -> day=1;
  - day_tick -> day stays 1;
  - btn_mode -> set_mode=0, day=1.
- Blink and timeout, TIMEOUT_TICKS=16:
  - after entering SET, blink_ticks give blank 1,0,1;
  - btn_inc -> blank=0 and the count restarts;
  - 16 further blink_ticks -> set_mode falls 1 cycle after the 16th, day retained.
- Coincidence:
  - btn_inc+btn_dec in SET -> day unchanged;
  - btn_mode+btn_inc in SET -> RUN with day unchanged;
  - day_tick+btn_mode in RUN at day=3 -> day=4 and set_mode=1.
- Scan: 4 scan_tick pulses in each mode -> digit_an 101,011,110,101 and digit_idx 1,2,0,1, with no multi-low glitch on any cycle.

Source files
------------

// File: rtl/day_pkg.sv
// rtl/day_pkg.sv - shared day codes, modulus, FSM states and day step helpers
package day_pkg;

  typedef enum logic [2:0] {
    MON = 3'd0,
    TUE = 3'd1,
    WED = 3'd2,
    THU = 3'd3,
    FRI = 3'd4,
    SAT = 3'd5,
    SUN = 3'd6
  } day_e;

  localparam int unsigned DAYS = 7;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_e;

  // Next day code modulo m; any out-of-range code folds back to 0.
  function automatic logic [2:0] day_step_up(input logic [2:0] d, input int unsigned m);
    return (32'(d) >= m - 1) ? 3'd0 : d + 3'd1;
  endfunction

  // Previous day code modulo m; 0 wraps to the last legal code.
  function automatic logic [2:0] day_step_down(input logic [2:0] d, input int unsigned m);
    return (d == 3'd0 || 32'(d) >= m) ? 3'(m - 1) : d - 3'd1;
  endfunction

endpackage

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - scan_tick driven digit index and one-hot active-low anodes
module digit_scanner #(
  parameter int NUM_DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scan_tick,
  output logic [1:0]            o_digit_idx,
  output logic [NUM_DIGITS-1:0] o_digit_an
);

  logic [1:0]            r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [1:0]            w_idx_nxt;

  // Advance the digit index, wrapping after the last digit.
  always_comb begin
    w_idx_nxt = r_idx;
    if (i_scan_tick) begin
      w_idx_nxt = (32'(r_idx) == NUM_DIGITS - 1) ? 2'd0 : r_idx + 2'd1;
    end
  end

  // Anodes are derived from the next index so both registers change together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= 2'd0;
      r_an  <= ~NUM_DIGITS'(1);
    end else begin
      r_idx <= w_idx_nxt;
      r_an  <= ~(NUM_DIGITS'(1) << w_idx_nxt);
    end
  end

  assign o_digit_idx = r_idx;
  assign o_digit_an  = r_an;

endmodule

// File: rtl/day_set_ctrl.sv
// rtl/day_set_ctrl.sv - day-of-week counter with SET edit mode, blink, timeout and digit scan
module day_set_ctrl #(
  parameter int NUM_DIGITS    = 3,
  parameter int TIMEOUT_TICKS = 16,
  parameter int DAYS          = day_pkg::DAYS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_day_tick,
  input  logic                  i_scan_tick,
  input  logic                  i_blink_tick,
  input  logic                  i_btn_mode,
  input  logic                  i_btn_inc,
  input  logic                  i_btn_dec,
  output logic [2:0]            o_day,
  output logic                  o_set_mode,
  output logic [NUM_DIGITS-1:0] o_digit_an,
  output logic [1:0]            o_digit_idx,
  output logic                  o_blank
);
  import day_pkg::*;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_day,   w_day_nxt;
  logic        r_phase, w_phase_nxt;
  logic [7:0]  r_cnt,   w_cnt_nxt;
  logic [7:0]  w_cnt_inc;
  logic        r_blank;

  assign w_cnt_inc = r_cnt + 8'd1;

  // Next-state logic: mode press beats buttons, buttons beat the blink/timeout tick.
  always_comb begin
    w_state_nxt = r_state;
    w_day_nxt   = r_day;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (i_day_tick) begin
          w_day_nxt = day_step_up(r_day, DAYS);
        end
        if (i_btn_mode) begin
          w_state_nxt = SET;
          w_phase_nxt = 1'b0;
          w_cnt_nxt   = 8'd0;
        end
      end
      SET: begin
        if (i_btn_mode) begin
          w_state_nxt = RUN;
          w_phase_nxt = 1'b0;
          w_cnt_nxt   = 8'd0;
        end else if (i_btn_inc || i_btn_dec) begin
          if (i_btn_inc && !i_btn_dec) begin
            w_day_nxt = day_step_up(r_day, DAYS);
          end else if (i_btn_dec && !i_btn_inc) begin
            w_day_nxt = day_step_down(r_day, DAYS);
          end
          w_phase_nxt = 1'b0;
          w_cnt_nxt   = 8'd0;
        end else if (i_blink_tick) begin
          w_phase_nxt = ~r_phase;
          if (32'(w_cnt_inc) >= TIMEOUT_TICKS) begin
            w_state_nxt = RUN;
            w_phase_nxt = 1'b0;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State, day, blink and timeout registers; blank is registered from next values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_day   <= MON;
      r_phase <= 1'b0;
      r_cnt   <= 8'd0;
      r_blank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_day   <= w_day_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_blank <= (w_state_nxt == SET) && w_phase_nxt;
    end
  end

  digit_scanner #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_scan (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scan_tick(i_scan_tick),
    .o_digit_idx(o_digit_idx),
    .o_digit_an (o_digit_an)
  );

  assign o_day      = r_day;
  assign o_set_mode = (r_state == SET);
  assign o_blank    = r_blank;

endmodule

// File: tb/tb_day_set_ctrl.sv
// tb/tb_day_set_ctrl.sv - directed self-checking bench for day_set_ctrl
`timescale 1ns/1ps
module tb_day_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0, scan_tick = 1'b0, blink_tick = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [2:0] day;
  logic       set_mode;
  logic [2:0] digit_an;
  logic [1:0] digit_idx;
  logic       blank;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_idx = 0;

  always #5 clk = ~clk;

  day_set_ctrl #(
    .NUM_DIGITS(3),
    .TIMEOUT_TICKS(16),
    .DAYS(7)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_day_tick  (day_tick),
    .i_scan_tick (scan_tick),
    .i_blink_tick(blink_tick),
    .i_btn_mode  (btn_mode),
    .i_btn_inc   (btn_inc),
    .i_btn_dec   (btn_dec),
    .o_day       (day),
    .o_set_mode  (set_mode),
    .o_digit_an  (digit_an),
    .o_digit_idx (digit_idx),
    .o_blank     (blank)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // v = {mode, inc, dec, day_tick, scan, blink}; held for one edge, sampled 1ns after it
  task automatic pulse(input logic [5:0] v);
    {btn_mode, btn_inc, btn_dec, day_tick, scan_tick, blink_tick} = v;
    @(posedge clk);
    #1;
    {btn_mode, btn_inc, btn_dec, day_tick, scan_tick, blink_tick} = '0;
  endtask

  localparam logic [5:0] P_MODE  = 6'b100000;
  localparam logic [5:0] P_INC   = 6'b010000;
  localparam logic [5:0] P_DEC   = 6'b001000;
  localparam logic [5:0] P_DAY   = 6'b000100;
  localparam logic [5:0] P_SCAN  = 6'b000010;
  localparam logic [5:0] P_BLINK = 6'b000001;

  task automatic scan_step;
    pulse(P_SCAN);
    exp_idx = (exp_idx + 1) % 3;
    chk("scan_idx", digit_idx, exp_idx);
    chk("scan_an", digit_an, 3'b111 & ~(3'b001 << exp_idx));
    chk("scan_onehot", $countones(~digit_an), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_day", day, 0);
    chk("rst_set", set_mode, 0);
    chk("rst_blank", blank, 0);
    chk("rst_an", digit_an, 3'b110);
    chk("rst_idx", digit_idx, 0);

    // RUN wrap and ignored inc
    for (int i = 1; i <= 6; i++) begin
      pulse(P_DAY);
      chk("run_day", day, i);
    end
    pulse(P_DAY);
    chk("run_wrap", day, 0);
    pulse(P_INC);
    chk("run_inc_ignored", day, 0);
    pulse(P_DEC);
    chk("run_dec_ignored", day, 0);

    // reach day 3, then day_tick + mode together
    repeat (3) pulse(P_DAY);
    chk("run_day3", day, 3);
    pulse(P_DAY | P_MODE);
    chk("daytick_mode_day", day, 4);
    chk("daytick_mode_set", set_mode, 1);
    pulse(P_BLINK);
    chk("preset_blank", blank, 1);
    scan_step();

    // async reset mid-SET without a clock edge
    rst_n = 1'b0;
    #1;
    chk("arst_day", day, 0);
    chk("arst_set", set_mode, 0);
    chk("arst_blank", blank, 0);
    chk("arst_an", digit_an, 3'b110);
    chk("arst_idx", digit_idx, 0);
    exp_idx = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_set", set_mode, 0);

    // SET edit
    pulse(P_MODE);
    chk("edit_enter", set_mode, 1);
    chk("edit_enter_blank", blank, 0);
    pulse(P_DEC);
    chk("edit_dec_wrap", day, 6);
    pulse(P_INC);
    chk("edit_inc_wrap", day, 0);
    pulse(P_INC);
    chk("edit_inc", day, 1);
    pulse(P_DAY);
    chk("edit_daytick_lost", day, 1);
    pulse(P_MODE);
    chk("edit_exit_set", set_mode, 0);
    chk("edit_exit_day", day, 1);

    // scan in RUN
    for (int i = 0; i < 4; i++) scan_step();
    @(posedge clk); #1;
    chk("scan_idle_onehot", $countones(~digit_an), 1);

    // blink and timeout
    pulse(P_MODE);
    chk("blink_enter", set_mode, 1);
    pulse(P_BLINK);
    chk("blink1", blank, 1);
    pulse(P_BLINK);
    chk("blink2", blank, 0);
    pulse(P_BLINK);
    chk("blink3", blank, 1);
    for (int i = 0; i < 4; i++) scan_step();
    chk("scan_set_blank_kept", blank, 1);
    pulse(P_INC);
    chk("blink_inc_blank", blank, 0);
    chk("blink_inc_day", day, 2);
    for (int i = 1; i <= 15; i++) pulse(P_BLINK);
    chk("tmo_15_set", set_mode, 1);
    chk("tmo_15_blank", blank, 1);
    pulse(P_BLINK);
    chk("tmo_16_set", set_mode, 0);
    chk("tmo_16_blank", blank, 0);
    chk("tmo_16_day", day, 2);

    // timeout tick coincident with a button: button wins
    pulse(P_MODE);
    for (int i = 1; i <= 15; i++) pulse(P_BLINK);
    pulse(P_BLINK | P_INC);
    chk("tmo_btn_set", set_mode, 1);
    chk("tmo_btn_day", day, 3);
    for (int i = 1; i <= 15; i++) pulse(P_BLINK);
    chk("tmo_btn_restart", set_mode, 1);

    // coincidences in SET
    pulse(P_INC | P_DEC);
    chk("incdec_day", day, 3);
    chk("incdec_set", set_mode, 1);
    pulse(P_MODE | P_INC);
    chk("mode_inc_set", set_mode, 0);
    chk("mode_inc_day", day, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
